// File: rtl/vc32_uart_pkg.sv
// Shared types and entry-layout helpers for the vc32 UART receiver.
package vc32_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    // FIFO entry layout: {perr, ferr, data[DATA_BITS-1:0]}
    function automatic int ferr_bit(input int data_bits);
        return data_bits;
    endfunction

    function automatic int perr_bit(input int data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Synchronous FIFO with a registered head-of-queue output.
module uart_rx_fifo_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok, push_ok;
    logic [AW-1:0]    rd_nxt;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rd_nxt  = rd_q + AW'(1);
    assign head_o  = head_q;
    assign level_o = lvl_q;

    // Next pointers, level and head register.
    always_comb begin
        rd_d   = pop_ok  ? rd_nxt : rd_q;
        wr_d   = push_ok ? wr_q + AW'(1) : wr_q;
        lvl_d  = lvl_q;
        head_d = head_q;
        if (push_ok && !pop_ok) lvl_d = lvl_q + LW'(1);
        if (pop_ok && !push_ok) lvl_d = lvl_q - LW'(1);
        if (pop_ok) begin
            // Next head comes from storage when it holds a second entry,
            // otherwise straight from the incoming write.
            if (lvl_q >= LW'(2))  head_d = mem_q[rd_nxt];
            else if (push_ok)     head_d = wdata_i;
        end else if (empty_o && push_ok) begin
            head_d = wdata_i;
        end
    end

    // Pointer/level/head state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            lvl_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            lvl_q  <= lvl_d;
            head_q <= head_d;
        end
    end

    // Storage array; contents are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampling, optional parity) feeding a receive FIFO.
module uart_rx_fifo
    import vc32_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     div,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [LW-1:0]        level,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 busy
);

    localparam int FERR_BIT = ferr_bit(DATA_BITS);
    localparam int PERR_BIT = perr_bit(DATA_BITS);
    localparam int EW       = DATA_BITS + 2;

    rx_state_e              state_q, state_d;
    logic                   s1_q, s2_q, prev_q;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bits_q, bits_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   perr_q, perr_d;
    logic                   ovr_q, ovr_d;
    logic                   fall, expire, push, ferr;
    logic [EW-1:0]          head;
    logic                   full, empty, drop;

    assign fall   = prev_q & ~s2_q;
    assign expire = (cnt_q == '0);

    // Two-flop synchronizer plus previous-sample register for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= rx;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // Receiver FSM: next state, bit timing and sample capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = expire ? cnt_q : cnt_q - DIV_W'(1);
        bits_d  = bits_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        push    = 1'b0;
        ferr    = 1'b0;
        // Counter runs down to 0 inclusive, so a reload of div-1 spaces
        // consecutive samples exactly div cycles apart.
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = div >> 1;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (expire) begin
                    if (s2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = div - DIV_W'(1);
                        bits_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    sh_d  = {s2_q, sh_q[DATA_BITS-1:1]};
                    cnt_d = div - DIV_W'(1);
                    if (bits_q == 4'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bits_d = bits_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (expire) begin
                    perr_d  = ((^sh_q) ^ s2_q) != 1'(PARITY_ODD);
                    cnt_d   = div - DIV_W'(1);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Push at mid-stop and rearm immediately for back-to-back frames.
                if (expire) begin
                    push    = 1'b1;
                    ferr    = ~s2_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
        end
    end

    uart_rx_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({perr_q, ferr, sh_q}),
        .pop_i   (rx_ready),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign drop  = push & full & ~(rx_ready & ~empty);
    // A fresh drop wins over a simultaneous clear.
    assign ovr_d = (ovr_q & ~ovr_clr) | drop;

    // Sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr_q <= 1'b0;
        else        ovr_q <= ovr_d;
    end

    assign rx_data  = head[DATA_BITS-1:0];
    assign rx_ferr  = head[FERR_BIT];
    assign rx_perr  = head[PERR_BIT];
    assign rx_valid = ~empty;
    assign overrun  = ovr_q;
    assign busy     = (state_q != S_IDLE);

endmodule
